// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register addresses,
// CTRL field positions, reset constants and the CTRL register layout.
package timer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned PS_W   = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL  = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_COUNT = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_MAX   = 2'b10;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_PS_LSB = 1;
    localparam int unsigned CTRL_PS_MSB = 3;
    localparam int unsigned CTRL_OS     = 4;

    localparam logic [DATA_W-1:0] MAX_RST = 16'hFFFF;

    // CTRL register fields as software sees them (bits [4:0])
    typedef struct packed {
        logic            os;
        logic [PS_W-1:0] ps;
        logic            en;
    } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler for mapped_timer.
// Ports: clk, rstn (sync, active-low), en (count enable), ps (divide select,
// divide by 2^ps), clear (restart from 0), tick (combinational count strobe).
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRE_W = 7
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [PS_W-1:0] ps,
    input  logic            clear,
    output logic            tick
);

    localparam logic [PRE_W-1:0] ONES = '1;

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] mask;

    // Free-running divider; held at zero while disabled or on a register write
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre <= '0;
        end else if (clear || !en) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // mask = (1 << ps) - 1, built by shifting zeros into an all-ones word
    assign mask = ~(ONES << ps);
    assign tick = en && ((pre & mask) == mask);

endmodule

// File: rtl/mapped_timer.sv
// Memory-mapped 16-bit up-counter timer with a one-cycle wrap interrupt.
// Ports: i_clk, i_rstn (sync, active-low), i_memAddr (register select),
// i_memDataIn / i_memWrEn (register write), o_memDataOut (combinational read
// data), o_intFlag (registered one-cycle wrap pulse).
// Optional one-shot mode (CTRL bit4) is built when MAPPED_TIMER_ONESHOT_EN
// is defined.
module mapped_timer
    import timer_pkg::*;
#(
    parameter int unsigned PRE_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [ADDR_W-1:0] i_memAddr,
    input  logic [DATA_W-1:0] i_memDataIn,
    input  logic              i_memWrEn,
    output logic [DATA_W-1:0] o_memDataOut,
    output logic              o_intFlag
);

    logic              en;
    logic [PS_W-1:0]   ps;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] max_val;
    logic              int_flag;
    logic              wr_ctrl;
    logic              wr_count;
    logic              wr_max;
    logic              tick;
    logic              wrap;
    ctrl_t             ctrl_rd;
`ifdef MAPPED_TIMER_ONESHOT_EN
    logic              os;
`endif

    assign wr_ctrl  = i_memWrEn && (i_memAddr == ADDR_CTRL);
    assign wr_count = i_memWrEn && (i_memAddr == ADDR_COUNT);
    assign wr_max   = i_memWrEn && (i_memAddr == ADDR_MAX);

    // A software COUNT write on a tick suppresses the wrap
    assign wrap = tick && !wr_count && (count >= max_val);

    timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk   (i_clk),
        .rstn  (i_rstn),
        .en    (en),
        .ps    (ps),
        .clear (wr_ctrl || wr_count),
        .tick  (tick)
    );

    // CTRL register; a same-cycle software write beats the one-shot auto-clear
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            en <= 1'b0;
            ps <= '0;
`ifdef MAPPED_TIMER_ONESHOT_EN
            os <= 1'b0;
`endif
        end else if (wr_ctrl) begin
            en <= i_memDataIn[CTRL_EN];
            ps <= i_memDataIn[CTRL_PS_MSB:CTRL_PS_LSB];
`ifdef MAPPED_TIMER_ONESHOT_EN
            os <= i_memDataIn[CTRL_OS];
        end else if (wrap && os) begin
            en <= 1'b0;
`endif
        end
    end

    // MAX register; the compare this cycle still sees the old value
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            max_val <= MAX_RST;
        end else if (wr_max) begin
            max_val <= i_memDataIn;
        end
    end

    // Counter and wrap pulse
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            count    <= '0;
            int_flag <= 1'b0;
        end else begin
            int_flag <= wrap;
            if (wr_count) begin
                count <= i_memDataIn;
            end else if (wrap) begin
                count <= '0;
            end else if (tick) begin
                count <= count + DATA_W'(1);
            end
        end
    end

    assign o_intFlag = int_flag;

    // CTRL readback image; unimplemented bits read zero
    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd.en = en;
        ctrl_rd.ps = ps;
`ifdef MAPPED_TIMER_ONESHOT_EN
        ctrl_rd.os = os;
`endif
    end

    // Read mux; no read side effects
    always_comb begin
        o_memDataOut = '0;
        case (i_memAddr)
            ADDR_CTRL:  o_memDataOut = DATA_W'(ctrl_rd);
            ADDR_COUNT: o_memDataOut = count;
            ADDR_MAX:   o_memDataOut = max_val;
            default:    o_memDataOut = '0;
        endcase
    end

endmodule

// File: doc/mapped_timer.md
Name: mapped_timer

Overview:
- Memory-mapped 16-bit up-counter timer with power-of-two prescaler.
- Generates a one-cycle interrupt flag pulse on each wrap.
- Sits directly upstream of the interrupt controller; its o_intFlag drives one of the controller's timer flag inputs (i_intTM0..3).
- Four instances exist in the design, one per timer flag.

Parameters:
- PRE_W, 7, prescaler counter width; max divide is 2^PRE_W.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; synchronous, active-low
- i_memAddr  in  2  register select
- i_memDataIn  in  16  write data
- i_memWrEn  in  1  write strobe for the addressed register
- o_memDataOut  out  16  read data (combinational from address)
- o_intFlag  out  1  one-cycle wrap pulse to interrupt controller

Behaviour:
- Register map:
  - 00 CTRL: bit0 EN, bits[3:1] PS; other bits read 0.
  - 01 COUNT: 16 bits.
  - 10 MAX: 16 bits.
  - 11: reads 0x0000; writes ignored.
- Reset (i_rstn=0 at a rising edge): EN=0, PS=0, COUNT=0, MAX=0xFFFF, prescaler=0, o_intFlag=0. Reset overrides any same-cycle write.
- Writes: take effect at the edge where i_memWrEn=1; readback shows the new value next cycle.
- Prescaler:
  - PRE_W-bit free counter, increments every cycle while EN=1.
  - Held at 0 while EN=0.
  - Cleared by any COUNT or CTRL write.
  - mask = (1<<PS)-1. tick = EN & ((pre & mask) == mask). PS=0 gives a tick every cycle; PS=7 gives a tick every 128 cycles.
- Counter, on tick:
  - If COUNT >= MAX: COUNT <= 0 and o_intFlag <= 1 on the same edge. The pulse is visible in the same cycle COUNT reads 0.
  - Otherwise COUNT <= COUNT+1 and o_intFlag <= 0.
  - MAX=0: COUNT stays 0 and pulses on every tick.
  - COUNT > MAX (after MAX is lowered): wraps on the next tick.
- o_intFlag is 0 in every cycle not following a wrap edge; never high two consecutive cycles unless PS=0 and MAX=0.
- Simultaneous COUNT write and tick: the write wins; COUNT <= written value, o_intFlag <= 0 (wrap suppressed).
- Simultaneous MAX write and tick: the compare uses the old MAX; the new MAX applies from the next tick.
- CTRL write clearing EN in the same cycle as a tick: the tick still completes (count/wrap happens); no ticks afterwards. COUNT holds its value while disabled.
- Output is purely combinational from the address and registers; no read side effects.

Optional Feature:
- Macro MAPPED_TIMER_ONESHOT_EN.
- Defined:
  - CTRL bit4 OS is implemented (reset 0, read/write).
  - When OS=1, the wrap edge also clears EN. The counter then stops at 0 after a single pulse until software re-sets EN.
  - A same-cycle CTRL write wins over the auto-clear.
- Undefined: bit4 reads 0, writes ignored, counter is always periodic.

Decomposition:
- Shared package timer_pkg holds:
  - address constants ADDR_CTRL=2'b00, ADDR_COUNT=2'b01, ADDR_MAX=2'b10
  - CTRL bit positions (EN=0, PS_LSB=1, PS_MSB=3, OS=4)
  - MAX reset constant 16'hFFFF
- One sub-module, timer_prescaler:
  - inputs: EN, PS, clear
  - output: tick
  - contains the PRE_W-bit counter and mask compare

Test Plan:
- Reset check: after reset, reads give CTRL=0x0000, COUNT=0x0000, MAX=0xFFFF, addr 11=0x0000; o_intFlag=0.
- Periodic wrap: MAX=3, PS=0, CTRL=0x0001 -> COUNT 1,2,3,0 repeating; o_intFlag high one cycle every 4 cycles, coincident with COUNT=0.
- Prescale: MAX=1, PS=2 (CTRL=0x0005) -> COUNT increments every 4 cycles; pulse every 8 cycles; disabling freezes COUNT at its value.
- Write collision: force a COUNT=0x0010 write on the wrap-tick cycle -> COUNT=0x0010, no pulse. Write MAX=2 while COUNT=5 -> wrap on next tick with pulse.
- Reset mid-run: assert i_rstn=0 mid-count with a simultaneous write -> all registers at reset values next cycle, o_intFlag=0.
- One-shot (macro defined): CTRL=0x0011, MAX=2 -> a single pulse; EN reads 0 afterwards and COUNT stays 0. Macro undefined: the same write yields periodic pulses and bit4 reads 0.
